// File: rtl/normalizer_if.sv
// Handshake bundle between a normalizer and its producer/consumer.
// The slave modport is the normalizer side; the master modport is the environment side.
interface normalizer_if #(
  parameter int Dw = 9,
  parameter int Sw = $clog2(Dw + 1)
);
  logic          valid_i;
  logic          ready_o;
  logic [Dw-1:0] data_i;
  logic          signed_i;
  logic          valid_o;
  logic          ready_i;
  logic [Dw-1:0] data_o;
  logic [Sw-1:0] shift_o;
  logic          zero_o;

  modport slave (
    input  valid_i, data_i, signed_i, ready_i,
    output ready_o, valid_o, data_o, shift_o, zero_o
  );

  modport master (
    output valid_i, data_i, signed_i, ready_i,
    input  ready_o, valid_o, data_o, shift_o, zero_o
  );
endinterface

// File: rtl/normalizer.sv
// Sequential leading-bit normalizer: shifts the captured word left one bit per cycle
// until it is normalized, reporting the shift count (leading zeros or redundant sign bits).
module normalizer #(
  parameter int Dw = 9,
  parameter int Sw = $clog2(Dw + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  normalizer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e        state_q, state_d;
  logic [Dw-1:0] work_q, work_d;
  logic [Sw-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          zero_q, zero_d;
  logic          stop;

  // Signed mode keeps one sign bit, so it saturates one shift earlier than unsigned.
  always_comb begin
    if (mode_q) begin
      stop = (work_q[Dw-1] != work_q[Dw-2]) || (cnt_q == Sw'(Dw - 1));
    end else begin
      stop = work_q[Dw-1] || (cnt_q == Sw'(Dw));
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          work_d  = bus.data_i;
          mode_d  = bus.signed_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (stop) begin
          state_d = DONE;
        end else begin
          work_d = {work_q[Dw-2:0], 1'b0};
          cnt_d  = cnt_q + Sw'(1);
        end
      end
      DONE: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    zero_d = (work_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake outputs depend on state alone; the result fields come straight from registers.
  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.data_o  = work_q;
  assign bus.shift_o = cnt_q;
  assign bus.zero_o  = zero_q;

endmodule

// File: tb/tb_normalizer.sv
// Randomized self-checking bench for normalizer: results are compared with a
// bit-counting reference model and round-tripped through a logical/arithmetic right shift.
module tb_normalizer;
  localparam int Dw = 9;
  localparam int Sw = $clog2(Dw + 1);

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  normalizer_if #(.Dw(Dw), .Sw(Sw)) bus ();

  normalizer #(.Dw(Dw), .Sw(Sw)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned counts zeros above the highest set bit; signed counts
  // bits below the MSB that still equal the sign bit.
  function automatic void model(input logic [Dw-1:0] x, input logic s,
                                output int sh, output logic [Dw-1:0] d);
    if (!s) begin
      sh = Dw;
      for (int b = 0; b < Dw; b++) if (x[b]) sh = Dw - 1 - b;
    end else begin
      sh = 0;
      for (int b = Dw - 2; b >= 0; b--) begin
        if (x[b] != x[Dw-1]) break;
        sh++;
      end
    end
    d = x << sh;
  endfunction

  task automatic run(input logic [Dw-1:0] x, input logic s, input int bp, input string tag);
    int              sh;
    int              n;
    logic [Dw-1:0]   d;
    logic [Dw-1:0]   hd;
    logic [Sw-1:0]   hs;
    logic            hz;
    logic [Dw-1:0]   rt;
    logic signed [Dw-1:0] sd;
    model(x, s, sh, d);
    @(negedge clk);
    check_eq({tag, "_ready_idle"}, 32'(bus.ready_o), 32'd1);
    bus.valid_i  = 1'b1;
    bus.data_i   = x;
    bus.signed_i = s;
    bus.ready_i  = (bp == 0);
    @(posedge clk); #1;
    bus.valid_i  = 1'b0;
    bus.data_i   = Dw'($urandom);
    bus.signed_i = 1'($urandom);
    n = 0;
    while (!bus.valid_o && n < 40) begin
      bus.valid_i = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    bus.valid_i = 1'b0;
    check_eq({tag, "_latency"}, 32'(n), 32'(sh + 1));
    check_eq({tag, "_data"}, 32'(bus.data_o), 32'(d));
    check_eq({tag, "_shift"}, 32'(bus.shift_o), 32'(sh));
    check_eq({tag, "_zero"}, 32'(bus.zero_o), 32'(x == '0));
    if (s) begin
      sd = bus.data_o;
      rt = sd >>> bus.shift_o;
    end else begin
      rt = bus.data_o >> bus.shift_o;
    end
    check_eq({tag, "_roundtrip"}, 32'(rt), 32'(x));
    hd = bus.data_o;
    hs = bus.shift_o;
    hz = bus.zero_o;
    for (int i = 0; i < bp; i++) begin
      bus.valid_i = 1'($urandom);
      bus.data_i  = Dw'($urandom);
      @(posedge clk); #1;
      check_eq({tag, "_bp_hold"}, {bus.valid_o, bus.ready_o, bus.zero_o, bus.shift_o, bus.data_o},
               {1'b1, 1'b0, hz, hs, hd});
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_after_hs"}, {bus.valid_o, bus.ready_o}, 2'b01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.signed_i = 1'b0;
    bus.ready_i  = 1'b1;
    #12;
    check_eq("reset_state", {bus.ready_o, bus.valid_o, bus.zero_o, bus.shift_o, bus.data_o},
             {1'b1, 1'b0, 1'b0, Sw'(0), Dw'(0)});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios with hand-derived results
    run(9'h1F0, 1'b0, 0, "u_1f0");
    check_eq("u_1f0_lit", {bus.shift_o, bus.data_o}, {Sw'(0), 9'h1F0});
    run(9'h001, 1'b0, 0, "u_001");
    check_eq("u_001_lit", {bus.shift_o, bus.data_o}, {Sw'(8), 9'h100});
    run(9'h000, 1'b0, 0, "u_000");
    check_eq("u_000_lit", {bus.zero_o, bus.shift_o, bus.data_o}, {1'b1, Sw'(9), 9'h000});
    run(9'h1F0, 1'b1, 0, "s_1f0");
    check_eq("s_1f0_lit", {bus.shift_o, bus.data_o}, {Sw'(4), 9'h100});
    run(9'h1FF, 1'b1, 0, "s_1ff");
    check_eq("s_1ff_lit", {bus.zero_o, bus.shift_o, bus.data_o}, {1'b0, Sw'(8), 9'h100});
    run(9'h000, 1'b1, 0, "s_000");
    check_eq("s_000_lit", {bus.zero_o, bus.shift_o, bus.data_o}, {1'b1, Sw'(8), 9'h000});
    run(9'h07F, 1'b1, 0, "s_07f");
    check_eq("s_07f_lit", {bus.shift_o, bus.data_o}, {Sw'(1), 9'h0FE});
    run(9'h003, 1'b0, 5, "u_bp");
    run(9'h1C0, 1'b1, 5, "s_bp");

    // Full sweeps with random backpressure
    for (int v = 0; v < 512; v++) run(Dw'(v), 1'b0, ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0, "sweep_u");
    for (int v = 0; v < 512; v++) run(Dw'(v), 1'b1, ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0, "sweep_s");
    for (int i = 0; i < 64; i++) run(Dw'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");

    // Reset in the middle of a shift sequence
    @(negedge clk);
    bus.valid_i  = 1'b1;
    bus.data_i   = 9'h001;
    bus.signed_i = 1'b0;
    bus.ready_i  = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_reset", {bus.ready_o, bus.valid_o, bus.zero_o, bus.shift_o, bus.data_o},
             {1'b1, 1'b0, 1'b0, Sw'(0), Dw'(0)});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check_eq("post_reset_quiet", {bus.valid_o, bus.ready_o}, 2'b01);
    end
    run(9'h020, 1'b0, 1, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
